// File: rtl/cmp_sched_pkg.sv
// cmp_sched_pkg: shared types and constants for the comparator scheduler
package cmp_sched_pkg;
    localparam int CMP_LAT_DEF = 2;
    localparam int CNT_W       = 32;
    localparam int DROP_W      = 8;
    localparam int CORE_W      = 4;
    localparam int TAG_NONCE_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [CORE_W-1:0]      core;
        logic [TAG_NONCE_W-1:0] nonce;
    } tag_t;
endpackage

// File: rtl/cmp_sched_rr_arb.sv
// rr_arb: round-robin arbiter, lowest request at or above ptr wins, else lowest overall
module rr_arb
    import cmp_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      req_i,
    input  logic [CORE_W-1:0] ptr_i,
    output logic [N-1:0]      gnt_o,
    output logic [CORE_W-1:0] idx_o,
    output logic              vld_o
);
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) begin
                idx_o = CORE_W'(i);
                vld_o = 1'b1;
            end
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i] && CORE_W'(i) >= ptr_i) idx_o = CORE_W'(i);
        gnt_o = vld_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin sharing of one pipelined hash-vs-target comparator among hash cores
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = TAG_NONCE_W,
    parameter int CMP_LAT   = CMP_LAT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [255:0]                 target,
    input  logic                         target_we,
    input  logic [NUM_CORES-1:0]         core_valid,
    input  logic [256*NUM_CORES-1:0]     core_hash,
    input  logic [NONCE_W*NUM_CORES-1:0] core_nonce,
    output logic [NUM_CORES-1:0]         core_ready,
    output logic [255:0]                 cmp_in,
    output logic [255:0]                 cmp_target,
    output logic                         cmp_read,
    input  logic                         cmp_out,
    input  logic                         cmp_write,
    output logic                         found_valid,
    output logic [NONCE_W-1:0]           found_nonce,
    output logic [CORE_W-1:0]            found_core,
    input  logic                         found_ready,
    output logic [CNT_W-1:0]             done_cnt,
    output logic [DROP_W-1:0]            drop_cnt,
    output logic                         busy,
    output logic                         err
);
    logic [NUM_CORES-1:0] full_q, full_d, gnt;
    logic [255:0]         hash_q [NUM_CORES];
    logic [NONCE_W-1:0]   nonce_q [NUM_CORES];
    logic [CORE_W-1:0]    ptr_q, ptr_d, gidx;
    logic                 gvld;
    tag_t                 tag_q [CMP_LAT];
    tag_t                 new_tag, tail;
    logic [255:0]         target_q, cmp_in_q, sel_hash;
    logic [NONCE_W-1:0]   sel_nonce, found_nonce_q, found_nonce_d;
    logic [CORE_W-1:0]    found_core_q, found_core_d;
    logic                 found_valid_q, found_valid_d;
    logic [CNT_W-1:0]     done_q, done_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic                 err_q, err_d, tag_busy;
    logic [7:0]           ign_q;
    logic                 wr, retire, hit, drain, load;

    rr_arb #(.N(NUM_CORES)) u_arb (
        .req_i (run ? full_q : '0),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .vld_o (gvld)
    );

    always_comb begin
        sel_hash  = '0;
        sel_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (gnt[i]) begin
                sel_hash  = hash_q[i];
                sel_nonce = nonce_q[i];
            end
        new_tag.valid = gvld;
        new_tag.core  = gidx;
        new_tag.nonce = TAG_NONCE_W'(sel_nonce);
        tail          = tag_q[CMP_LAT-1];
        tag_busy      = 1'b0;
        for (int i = 0; i < CMP_LAT; i++) tag_busy = tag_busy | tag_q[i].valid;
        full_d        = (full_q & ~gnt) | (core_valid & ~full_q);
        ptr_d         = !gvld ? ptr_q : (gidx == CORE_W'(NUM_CORES - 1)) ? '0 : gidx + 1'b1;
        // Strobes from compares issued before a reset are swallowed for CMP_LAT cycles
        wr            = cmp_write && ign_q == '0;
        retire        = wr && tail.valid;
        err_d         = err_q | (wr ^ tail.valid);
        hit           = retire && cmp_out;
        drain         = found_valid_q && found_ready;
        load          = hit && (!found_valid_q || drain);
        found_valid_d = load | (found_valid_q & ~drain);
        found_nonce_d = load ? NONCE_W'(tail.nonce) : found_nonce_q;
        found_core_d  = load ? tail.core : found_core_q;
        done_d        = done_q + CNT_W'(retire);
        drop_d        = (hit && !load && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q        <= '0;
            ptr_q         <= '0;
            target_q      <= '0;
            cmp_in_q      <= '0;
            found_valid_q <= 1'b0;
            found_nonce_q <= '0;
            found_core_q  <= '0;
            done_q        <= '0;
            drop_q        <= '0;
            err_q         <= 1'b0;
            ign_q         <= 8'(CMP_LAT);
            for (int i = 0; i < CMP_LAT; i++) tag_q[i] <= '0;
        end else begin
            full_q        <= full_d;
            ptr_q         <= ptr_d;
            target_q      <= target_we ? target : target_q;
            cmp_in_q      <= gvld ? sel_hash : cmp_in_q;
            found_valid_q <= found_valid_d;
            found_nonce_q <= found_nonce_d;
            found_core_q  <= found_core_d;
            done_q        <= done_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
            ign_q         <= (ign_q != '0) ? ign_q - 1'b1 : ign_q;
            tag_q[0]      <= new_tag;
            for (int i = 1; i < CMP_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (core_valid[i] && !full_q[i]) begin
                hash_q[i]  <= core_hash[256*i +: 256];
                nonce_q[i] <= core_nonce[NONCE_W*i +: NONCE_W];
            end
    end

    assign core_ready  = ~full_q;
    assign cmp_read    = gvld;
    assign cmp_in      = gvld ? sel_hash : cmp_in_q;
    assign cmp_target  = target_q;
    assign found_valid = found_valid_q;
    assign found_nonce = found_nonce_q;
    assign found_core  = found_core_q;
    assign done_cnt    = done_q;
    assign drop_cnt    = drop_q;
    assign busy        = (|full_q) | tag_busy;
    assign err         = err_q;
endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: directed scenarios for cmp_sched with a 2-stage comparator stand-in
module tb_cmp_sched;
    localparam int N = 4, NW = 32, LAT = 2;

    logic            clk = 1'b0, rst = 1'b1, run = 1'b0, target_we = 1'b0, found_ready = 1'b0;
    logic [255:0]    target = '0, cmp_in, cmp_target;
    logic [N-1:0]    core_valid = '0, core_ready;
    logic [256*N-1:0] core_hash = '0;
    logic [NW*N-1:0] core_nonce = '0;
    logic            cmp_read, cmp_out, cmp_write, found_valid, busy, err;
    logic [NW-1:0]   found_nonce;
    logic [3:0]      found_core;
    logic [31:0]     done_cnt;
    logic [7:0]      drop_cnt;
    logic            inj_wr = 1'b0, kill = 1'b0;
    logic [LAT-1:0]  pipe_rd = '0, pipe_hit = '0;
    int              n_pass = 0, n_total = 0;

    cmp_sched #(.NUM_CORES(N), .NONCE_W(NW), .CMP_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .run(run), .target(target), .target_we(target_we),
        .core_valid(core_valid), .core_hash(core_hash), .core_nonce(core_nonce),
        .core_ready(core_ready), .cmp_in(cmp_in), .cmp_target(cmp_target), .cmp_read(cmp_read),
        .cmp_out(cmp_out), .cmp_write(cmp_write), .found_valid(found_valid),
        .found_nonce(found_nonce), .found_core(found_core), .found_ready(found_ready),
        .done_cnt(done_cnt), .drop_cnt(drop_cnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: not reset, so strobes for pre-reset issues still arrive late
    always @(posedge clk) begin
        pipe_rd  <= {pipe_rd[LAT-2:0], cmp_read};
        pipe_hit <= {pipe_hit[LAT-2:0], cmp_read && (cmp_in < cmp_target)};
    end
    assign cmp_write = (pipe_rd[LAT-1] & ~kill) | inj_wr;
    assign cmp_out   = pipe_hit[LAT-1] & ~kill;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_core(input int i, input logic [255:0] h, input logic [NW-1:0] n);
        core_hash[256*i +: 256] = h;
        core_nonce[NW*i +: NW]  = n;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; run = 1'b0; core_valid = '0; target_we = 1'b0;
        found_ready = 1'b0; inj_wr = 1'b0; kill = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (core_ready !== 4'hF) $display("FAIL reset_ready: got %h want f", core_ready); else n_pass++;
        n_total++; if (cmp_read !== 1'b0 || cmp_in !== '0 || cmp_target !== '0)
            $display("FAIL reset_cmp: read %b in %h tgt %h want 0", cmp_read, cmp_in, cmp_target); else n_pass++;
        n_total++; if (found_valid !== 1'b0 || found_nonce !== '0 || found_core !== '0)
            $display("FAIL reset_found: v %b n %h c %h want 0", found_valid, found_nonce, found_core); else n_pass++;
        n_total++; if (done_cnt !== 0 || drop_cnt !== 0 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_status: done %0d drop %0d busy %b err %b want 0", done_cnt, drop_cnt, busy, err); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        target = 256'h10; target_we = 1'b1; run = 1'b1; core_valid = 4'b0001;
        set_core(0, 256'h1, 32'hCAFE0001);
        #1;
        n_total++; if (core_ready[0] !== 1'b1) $display("FAIL single_ready0: got %b want 1", core_ready[0]); else n_pass++;
        tick(); target_we = 1'b0; core_valid = '0; #1;
        n_total++; if (cmp_read !== 1'b1 || cmp_in !== 256'h1 || cmp_target !== 256'h10)
            $display("FAIL single_issue: read %b in %h tgt %h want 1/1/10", cmp_read, cmp_in, cmp_target); else n_pass++;
        n_total++; if (core_ready !== 4'b1110) $display("FAIL single_slot_full: got %b want 1110", core_ready); else n_pass++;
        tick(); #1;
        n_total++; if (cmp_read !== 1'b0 || core_ready !== 4'hF || busy !== 1'b1)
            $display("FAIL single_after_issue: read %b ready %h busy %b want 0/f/1", cmp_read, core_ready, busy); else n_pass++;
        tick(); #1;
        n_total++; if (found_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_retire_cycle: fv %b busy %b want 0/1", found_valid, busy); else n_pass++;
        tick(); #1;
        n_total++; if (found_valid !== 1'b1 || found_nonce !== 32'hCAFE0001 || found_core !== 4'd0)
            $display("FAIL single_found: v %b n %h c %0d want 1/cafe0001/0", found_valid, found_nonce, found_core); else n_pass++;
        n_total++; if (done_cnt !== 32'd1 || busy !== 1'b0)
            $display("FAIL single_done: done %0d busy %b want 1/0", done_cnt, busy); else n_pass++;
        found_ready = 1'b1;
        tick(); found_ready = 1'b0; #1;
        n_total++; if (found_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", found_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [255:0] exp_h;
        do_reset();
        target = 256'h10; target_we = 1'b1; run = 1'b1; core_valid = 4'hF;
        for (int i = 0; i < N; i++) set_core(i, 256'h100 + 256'(i), 32'h100 + 32'(i));
        for (int k = 0; k < 8; k++) begin
            tick(); target_we = 1'b0; #1;
            exp_h = 256'h100 + 256'(k % N);
            n_total++; if (cmp_read !== 1'b1 || cmp_in !== exp_h)
                $display("FAIL rr_grant%0d: read %b in %h want 1/%h", k, cmp_read, cmp_in, exp_h); else n_pass++;
        end
        tick(); run = 1'b0; core_valid = '0; #1;
        n_total++; if (cmp_read !== 1'b0) $display("FAIL rr_run_off: read %b want 0", cmp_read); else n_pass++;
        repeat (3) tick();
        #1;
        n_total++; if (done_cnt !== 32'd8 || found_valid !== 1'b0)
            $display("FAIL rr_done: done %0d fv %b want 8/0", done_cnt, found_valid); else n_pass++;
        n_total++; if (core_ready !== 4'b1000 || busy !== 1'b1)
            $display("FAIL rr_slots: ready %b busy %b want 1000/1", core_ready, busy); else n_pass++;
    endtask

    task automatic test_target_we();
        do_reset();
        target = 256'h10; target_we = 1'b1; run = 1'b1; core_valid = 4'b0011;
        set_core(0, 256'h20, 32'hA0); set_core(1, 256'h20, 32'hA1);
        tick(); core_valid = '0; target = '1; target_we = 1'b1; #1;
        n_total++; if (cmp_read !== 1'b1 || cmp_in !== 256'h20 || cmp_target !== 256'h10)
            $display("FAIL tgt_old: read %b in %h tgt %h want 1/20/10", cmp_read, cmp_in, cmp_target); else n_pass++;
        tick(); target_we = 1'b0; #1;
        n_total++; if (cmp_read !== 1'b1 || cmp_target !== {256{1'b1}})
            $display("FAIL tgt_new: read %b tgt %h want 1/all-ones", cmp_read, cmp_target); else n_pass++;
        repeat (3) tick();
        #1;
        n_total++; if (found_valid !== 1'b1 || found_core !== 4'd1 || found_nonce !== 32'hA1 || done_cnt !== 32'd2)
            $display("FAIL tgt_hit: v %b c %0d n %h done %0d want 1/1/a1/2", found_valid, found_core, found_nonce, done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        target = '1; target_we = 1'b1; run = 1'b1; core_valid = 4'b0011;
        set_core(0, 256'h1, 32'hB0); set_core(1, 256'h1, 32'hB1);
        tick(); target_we = 1'b0; core_valid = '0;
        repeat (4) tick();
        #1;
        n_total++; if (found_valid !== 1'b1 || found_nonce !== 32'hB0 || drop_cnt !== 8'd1 || done_cnt !== 32'd2)
            $display("FAIL b2b_drop: v %b n %h drop %0d done %0d want 1/b0/1/2", found_valid, found_nonce, drop_cnt, done_cnt); else n_pass++;
        set_core(2, 256'h1, 32'hB2); set_core(3, 256'h1, 32'hB3); core_valid = 4'b1100;
        tick(); core_valid = '0;
        tick();
        tick(); found_ready = 1'b1;
        tick(); #1;
        n_total++; if (found_valid !== 1'b1 || found_nonce !== 32'hB2 || found_core !== 4'd2 || drop_cnt !== 8'd1)
            $display("FAIL b2b_drain_load: v %b n %h c %0d drop %0d want 1/b2/2/1", found_valid, found_nonce, found_core, drop_cnt); else n_pass++;
        tick(); #1;
        n_total++; if (found_valid !== 1'b1 || found_nonce !== 32'hB3 || found_core !== 4'd3 || drop_cnt !== 8'd1 || done_cnt !== 32'd4)
            $display("FAIL b2b_second: v %b n %h c %0d drop %0d done %0d want 1/b3/3/1/4", found_valid, found_nonce, found_core, drop_cnt, done_cnt); else n_pass++;
        tick(); found_ready = 1'b0; #1;
        n_total++; if (found_valid !== 1'b0) $display("FAIL b2b_release: v %b want 0", found_valid); else n_pass++;
    endtask

    task automatic test_err();
        do_reset();
        repeat (3) tick();
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL err_idle: got %b want 0", err); else n_pass++;
        inj_wr = 1'b1;
        tick(); inj_wr = 1'b0; #1;
        n_total++; if (err !== 1'b1) $display("FAIL err_stray_write: got %b want 1", err); else n_pass++;
        repeat (5) tick();
        #1;
        n_total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
        do_reset();
        n_total++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else n_pass++;
        kill = 1'b1; run = 1'b1; core_valid = 4'b0001; set_core(0, 256'h5, 32'hD0);
        tick(); core_valid = '0;
        repeat (3) tick();
        #1;
        n_total++; if (err !== 1'b1) $display("FAIL err_missing_write: got %b want 1", err); else n_pass++;
    endtask

    task automatic test_rst_inflight();
        do_reset();
        target = '1; target_we = 1'b1; run = 1'b1; core_valid = 4'hF;
        for (int i = 0; i < N; i++) set_core(i, 256'h1, 32'hE0 + 32'(i));
        tick(); target_we = 1'b0; core_valid = 4'b0001;
        tick();
        tick(); rst = 1'b1; run = 1'b0; core_valid = '0; #1;
        n_total++; if (core_ready !== 4'b0010 || busy !== 1'b1)
            $display("FAIL rst_pre: ready %b busy %b want 0010/1", core_ready, busy); else n_pass++;
        tick(); rst = 1'b0; #1;
        n_total++; if (core_ready !== 4'hF || found_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_state: ready %h fv %b busy %b want f/0/0", core_ready, found_valid, busy); else n_pass++;
        n_total++; if (done_cnt !== 0 || drop_cnt !== 0 || err !== 1'b0)
            $display("FAIL rst_counters: done %0d drop %0d err %b want 0", done_cnt, drop_cnt, err); else n_pass++;
        repeat (3) tick();
        #1;
        n_total++; if (err !== 1'b0 || done_cnt !== 0 || found_valid !== 1'b0)
            $display("FAIL rst_late_write: err %b done %0d fv %b want 0/0/0", err, done_cnt, found_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_target_we();
        test_back_to_back();
        test_err();
        test_rst_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
